// File: rtl/key_scheduler.sv
// RC4 key-scheduling stage. Fills the 256-entry scratch RAM with the identity permutation,
// then runs the key-driven swap loop so S holds the permutation the decrypter consumes.
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   start       begin scheduling; only sampled while idle
//   secret_key  KEY_LEN bytes, MSB byte is key[0]
//   s_addr      scratch RAM address
//   s_data      scratch RAM write data
//   s_q         scratch RAM read data, valid the cycle after s_addr is presented
//   s_wren      scratch RAM write enable
//   busy        high from start acceptance through the finish cycle
//   finish      one-cycle pulse when S is complete
//
// State and outputs are registered together, so the state a cycle is in names exactly the
// RAM operation visible on the ports during that cycle.
module key_scheduler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned KEY_LEN    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEY_LEN*8-1:0]   secret_key,
  output logic [ADDR_WIDTH-1:0]  s_addr,
  output logic [DATA_WIDTH-1:0]  s_data,
  input  logic [DATA_WIDTH-1:0]  s_q,
  output logic                   s_wren,
  output logic                   busy,
  output logic                   finish
);

  localparam int unsigned KidxW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StInit,
    StRdSi,
    StWtSi,
    StRdSj,
    StWtSj,
    StWrSi,
    StWrSj,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  i_q, i_d;
  logic [ADDR_WIDTH-1:0]  j_q, j_d;
  logic [DATA_WIDTH-1:0]  si_q, si_d;
  logic [KEY_LEN*8-1:0]   key_q, key_d;
  logic [KidxW-1:0]       kidx_q, kidx_d;   // i mod KEY_LEN, kept as a wrapping counter
  logic [ADDR_WIDTH-1:0]  s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0]  s_data_q, s_data_d;
  logic                   s_wren_q, s_wren_d;
  logic                   busy_q, busy_d;
  logic                   finish_q, finish_d;

  logic [7:0]             key_byte;
  logic [ADDR_WIDTH-1:0]  j_sum;

  // Select key[i mod KEY_LEN]; byte 0 sits in the most significant position.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < int'(KEY_LEN); k++) begin
      if (kidx_q == KidxW'(k)) begin
        key_byte = key_q[(int'(KEY_LEN) - 1 - k) * 8 +: 8];
      end
    end
  end

  // s_q is S[i] while in StWtSi; the new j is also the next read address.
  assign j_sum = j_q + ADDR_WIDTH'(s_q) + ADDR_WIDTH'(key_byte);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    key_d    = key_q;
    kidx_d   = kidx_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    s_wren_d = 1'b0;
    busy_d   = busy_q;
    finish_d = 1'b0;

    case (state_q)
      StIdle: begin
        busy_d   = 1'b0;
        s_addr_d = '0;
        s_data_d = '0;
        if (start) begin
          key_d    = secret_key;
          i_d      = '0;
          j_d      = '0;
          kidx_d   = '0;
          busy_d   = 1'b1;
          s_wren_d = 1'b1;  // first INIT write: S[0] = 0
          state_d  = StInit;
        end
      end

      StInit: begin
        if (i_q == '1) begin
          i_d      = '0;
          s_addr_d = '0;
          state_d  = StRdSi;
        end else begin
          i_d      = i_q + ADDR_WIDTH'(1);
          s_addr_d = i_q + ADDR_WIDTH'(1);
          s_data_d = DATA_WIDTH'(i_q + ADDR_WIDTH'(1));
          s_wren_d = 1'b1;
        end
      end

      StRdSi: state_d = StWtSi;

      StWtSi: begin
        si_d     = s_q;
        j_d      = j_sum;
        s_addr_d = j_sum;
        state_d  = StRdSj;
      end

      StRdSj: state_d = StWtSj;

      StWtSj: begin
        s_addr_d = i_q;
        s_data_d = s_q;
        s_wren_d = 1'b1;
        state_d  = StWrSi;
      end

      StWrSi: begin
        s_addr_d = j_q;
        s_data_d = si_q;
        s_wren_d = 1'b1;
        state_d  = StWrSj;
      end

      StWrSj: begin
        if (i_q == '1) begin
          s_addr_d = '0;
          s_data_d = '0;
          finish_d = 1'b1;
          state_d  = StDone;
        end else begin
          i_d      = i_q + ADDR_WIDTH'(1);
          kidx_d   = (kidx_q == KidxW'(KEY_LEN - 1)) ? '0 : kidx_q + KidxW'(1);
          s_addr_d = i_q + ADDR_WIDTH'(1);
          state_d  = StRdSi;
        end
      end

      StDone: begin
        busy_d   = 1'b0;
        s_addr_d = '0;
        s_data_d = '0;
        state_d  = StIdle;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      si_q     <= '0;
      key_q    <= '0;
      kidx_q   <= '0;
      s_addr_q <= '0;
      s_data_q <= '0;
      s_wren_q <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      si_q     <= si_d;
      key_q    <= key_d;
      kidx_q   <= kidx_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      s_wren_q <= s_wren_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign s_addr = s_addr_q;
  assign s_data = s_data_q;
  assign s_wren = s_wren_q;
  assign busy   = busy_q;
  assign finish = finish_q;

endmodule
